// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
//
// Sends one command byte to a PS/2 device over the shared open-drain clock/data pair.
// It runs the request-to-send sequence (clock inhibit, then data low), shifts the byte
// out LSB first on device clock falling edges, appends odd parity and a stop bit, and
// checks the device acknowledge before reporting completion.
//
// Ports:
//   clock    - system clock, all logic on the rising edge
//   resetn   - asynchronous active-low reset; releases both lines immediately
//   start    - single-cycle send request, sampled only while idle
//   data     - byte to send, latched when start is accepted
//   ps2c_in  - raw PS/2 clock pin level (asynchronous)
//   ps2d_in  - raw PS/2 data pin level (asynchronous)
//   ps2c_oe  - 1 pulls the PS/2 clock line low, 0 releases it
//   ps2d_oe  - 1 pulls the PS/2 data line low, 0 releases it
//   busy     - high while a transfer is in progress
//   done     - one-cycle pulse when the device acknowledged the byte
//   error    - one-cycle pulse on watchdog timeout or missing acknowledge

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned START_HOLD     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] data,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       error
);

    // One counter serves the inhibit, start-hold and watchdog phases; they never overlap.
    localparam int unsigned MaxAb     = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES
                                                                      : START_HOLD;
    localparam int unsigned MaxCycles = (MaxAb > TIMEOUT_CYCLES) ? MaxAb : TIMEOUT_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

    localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] StartLast   = CntW'(START_HOLD - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StSend,
        StAck,
        StWaitRel
    } state_e;

    state_e state_q, state_d;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            c_oe_q, c_oe_d;
    logic            d_oe_q, d_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    // Synchronisers. They reset to 1 (idle bus level) so reset release cannot fake a fall.
    logic c_meta_q, c_sync_q, c_prev_q;
    logic d_meta_q, d_sync_q;
    logic fall;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            c_meta_q <= 1'b1;
            c_sync_q <= 1'b1;
            c_prev_q <= 1'b1;
            d_meta_q <= 1'b1;
            d_sync_q <= 1'b1;
        end else begin
            c_meta_q <= ps2c_in;
            c_sync_q <= c_meta_q;
            c_prev_q <= c_sync_q;
            d_meta_q <= ps2d_in;
            d_sync_q <= d_meta_q;
        end
    end

    assign fall = c_prev_q & ~c_sync_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        c_oe_d   = c_oe_q;
        d_oe_d   = d_oe_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                busy_d = 1'b0;
                // A request landing on a done/error pulse belongs to the finishing frame.
                if (start && !done_q && !error_q) begin
                    shreg_d = data;
                    par_d   = ~^data;
                    cnt_d   = '0;
                    c_oe_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StInhibit;
                end
            end

            StInhibit: begin
                if (cnt_q == InhibitLast) begin
                    cnt_d   = '0;
                    d_oe_d  = 1'b1;
                    state_d = StStart;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StStart: begin
                if (cnt_q == StartLast) begin
                    // Release the clock; data stays low as the start bit.
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    c_oe_d   = 1'b0;
                    state_d  = StSend;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StSend: begin
                if (fall) begin
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (bitcnt_q < 4'd8) begin
                        d_oe_d = ~shreg_q[bitcnt_q[2:0]];
                    end else if (bitcnt_q == 4'd8) begin
                        d_oe_d = ~par_q;
                    end else begin
                        d_oe_d  = 1'b0;
                        state_d = StAck;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d   = '0;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StAck: begin
                if (fall) begin
                    cnt_d    = '0;
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (!d_sync_q) begin
                        state_d = StWaitRel;
                    end else begin
                        c_oe_d  = 1'b0;
                        d_oe_d  = 1'b0;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                        state_d = StIdle;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d   = '0;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StWaitRel: begin
                if (c_sync_q && d_sync_q) begin
                    cnt_d   = '0;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (cnt_q == TimeoutLast) begin
                    cnt_d   = '0;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            default: begin
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            c_oe_q   <= 1'b0;
            d_oe_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            c_oe_q   <= c_oe_d;
            d_oe_q   <= d_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign ps2c_oe = c_oe_q;
    assign ps2d_oe = d_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign error   = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns / 1ps

// Directed bench for ps2_host_tx with a PS/2 device model clocking at a 40-cycle period.
module tb_ps2_host_tx;

    localparam int unsigned INH = 20;
    localparam int unsigned SH  = 4;
    localparam int unsigned TO  = 200;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [7:0] data;
    logic       dev_clk;
    logic       dev_dat;
    wire        ps2c_in;
    wire        ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       busy;
    logic       done;
    logic       error;

    int n_err     = 0;
    int n_chk     = 0;
    int tick      = 0;
    int last_fall = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;

    // Open-drain bus: a line is high only if nobody pulls it low.
    assign ps2c_in = dev_clk & ~ps2c_oe;
    assign ps2d_in = dev_dat & ~ps2d_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .START_HOLD    (SH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .data   (data),
        .ps2c_in(ps2c_in),
        .ps2d_in(ps2d_in),
        .ps2c_oe(ps2c_oe),
        .ps2d_oe(ps2d_oe),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (done)  done_cnt <= done_cnt + 1;
        if (error) err_cnt  <= err_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running, required to finish");
        $fatal(1, "global timeout");
    end

    task automatic tk(input int n = 1);
        repeat (n) begin
            @(negedge clock);
            tick++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Device model: generates n_falls clock pulses, samples data on each rising edge,
    // drives the ack bit before fall 11. rst_at / busy_start_at inject events at a fall.
    task automatic device(input int n_falls, input logic ack, input int rst_at,
                          input int busy_start_at, output logic [10:0] bits);
        bits = '0;
        for (int f = 1; f <= n_falls; f++) begin
            dev_clk   = 1'b0;
            last_fall = tick;
            if (f == rst_at) begin
                tk(5);
                resetn = 1'b0;
                #1;
                chk("rst_async_ps2c_oe", ps2c_oe, 0);
                chk("rst_async_ps2d_oe", ps2d_oe, 0);
                chk("rst_async_busy", busy, 0);
                tk(3);
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                tk(3);
                resetn = 1'b1;
                tk(2);
                return;
            end else if (f == busy_start_at) begin
                start = 1'b1;
                data  = 8'h55;
                tk(1);
                start = 1'b0;
                tk(19);
            end else begin
                tk(20);
            end
            dev_clk     = 1'b1;
            bits[f-1]   = ps2d_in;
            tk(10);
            if (f == 10 && n_falls == 11) dev_dat = ack;
            tk(10);
        end
        dev_dat = 1'b1;
    endtask

    // Issue start and wait (bounded) for the host to release the clock after inhibit.
    task automatic launch(input string tag, input logic [7:0] val, input bit timing);
        data  = val;
        start = 1'b1;
        tk(1);
        start = 1'b0;
        data  = 8'h00;
        chk({tag, "_busy_accept"}, busy, 1);
        if (timing) begin
            for (int k = 1; k <= 24; k++) begin
                chk({tag, "_inh_ps2c_oe"}, ps2c_oe, 1);
                chk({tag, "_inh_ps2d_oe"}, ps2d_oe, (k >= 21) ? 1 : 0);
                tk(1);
            end
        end else begin
            for (int i = 0; i < 60 && ps2c_oe; i++) tk(1);
        end
        chk({tag, "_release_ps2c_oe"}, ps2c_oe, 0);
        chk({tag, "_start_bit_oe"}, ps2d_oe, 1);
        chk({tag, "_start_bit_line"}, ps2d_in, 0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] val, input logic exp_par,
                             input logic ack, input int busy_start_at, input bit timing);
        int d0;
        int e0;
        logic [10:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        launch(tag, val, timing);
        tk(10);
        device(11, ack, 0, busy_start_at, bits);
        if (!ack) begin
            for (int i = 0; i < 50 && !done; i++) tk(1);
            chk({tag, "_done_pulse"}, done, 1);
            chk({tag, "_busy_with_done"}, busy, 0);
            // Request on the done cycle must be ignored.
            start = 1'b1;
            tk(1);
            start = 1'b0;
            chk({tag, "_done_one_cycle"}, done, 0);
            tk(1);
            chk({tag, "_start_on_done_ignored"}, busy, 0);
            chk({tag, "_idle_ps2c_oe"}, ps2c_oe, 0);
            chk({tag, "_done_count"}, done_cnt - d0, 1);
            chk({tag, "_no_error"}, err_cnt - e0, 0);
        end else begin
            chk({tag, "_error_count"}, err_cnt - e0, 1);
            chk({tag, "_no_done"}, done_cnt - d0, 0);
            chk({tag, "_err_busy"}, busy, 0);
            chk({tag, "_err_ps2c_oe"}, ps2c_oe, 0);
            chk({tag, "_err_ps2d_oe"}, ps2d_oe, 0);
        end
        chk({tag, "_data_bits"}, bits[7:0], val);
        chk({tag, "_parity"}, bits[8], exp_par);
        chk({tag, "_stop"}, bits[9], 1);
        chk({tag, "_ack_line"}, bits[10], ack);
    endtask

    initial begin
        int e0;
        logic [10:0] bits;
        resetn  = 1'b0;
        start   = 1'b0;
        data    = 8'h00;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        tk(3);
        chk("reset_ps2c_oe", ps2c_oe, 0);
        chk("reset_ps2d_oe", ps2d_oe, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        resetn = 1'b1;
        tk(2);

        // 0xED: 1,0,1,1,0,1,1,1 LSB first, six ones -> parity 1.
        run_frame("ed", 8'hED, 1'b1, 1'b0, 0, 1'b1);
        run_frame("x01", 8'h01, 1'b0, 1'b0, 0, 1'b0);
        run_frame("xff", 8'hFF, 1'b1, 1'b0, 0, 1'b0);
        run_frame("x00", 8'h00, 1'b1, 1'b0, 0, 1'b0);

        // Device leaves data high at fall 11.
        run_frame("noack", 8'hED, 1'b1, 1'b1, 0, 1'b0);

        // Device stops after fall 4: error 3 sync/detect cycles + TO cycles after the pin fall.
        e0 = err_cnt;
        launch("tmo", 8'h3C, 1'b0);
        tk(10);
        device(4, 1'b0, 0, 0, bits);
        for (int i = 0; i < 400 && !error; i++) tk(1);
        chk("tmo_error_pulse", error, 1);
        chk("tmo_latency", tick - last_fall, 3 + TO);
        chk("tmo_busy", busy, 0);
        chk("tmo_ps2c_oe", ps2c_oe, 0);
        chk("tmo_ps2d_oe", ps2d_oe, 0);
        chk("tmo_bits_1_4", bits[3:0], 4'hC);
        tk(2);
        chk("tmo_error_count", err_cnt - e0, 1);

        // Reset during fall 6, then a full frame; 0x96 has four ones -> parity 1.
        launch("rst", 8'h5A, 1'b0);
        tk(10);
        device(11, 1'b0, 6, 0, bits);
        chk("rst_idle_busy", busy, 0);
        run_frame("after_rst", 8'h96, 1'b1, 1'b0, 0, 1'b0);

        // Start with 0x55 during fall 3 must not disturb the 0xED frame.
        run_frame("busy_start", 8'hED, 1'b1, 1'b0, 3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter. Sends one command byte to the keyboard, such as 0xED (set LEDs) or 0xFF (reset), over the same open-drain PS2_KBCLK/PS2_KBDAT pair the keyboard receiver listens on. It runs the full host request-to-send sequence, frames the byte with odd parity, and checks the device acknowledge. It sits beside `keyboard` in `cowboy_gunner`; while `busy` is high, the top level must ignore `kb_sc_ready`.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 6000: cycles `ps2c_oe` is held low before the start bit (120 µs at 50 MHz).
- `START_HOLD`, 50: cycles both lines are held low before the clock is released.
- `TIMEOUT_CYCLES`, 750000: maximum gap (15 ms) between device clock falling edges, and from release to the first falling edge.

Ports:
- `clock`, in, 1: 50 MHz system clock; all logic on the rising edge.
- `resetn`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: single-cycle request; sampled only in IDLE.
- `data`, in, 8: byte to send; latched on an accepted `start`.
- `ps2c_in`, in, 1: raw PS2_KBCLK pin level.
- `ps2d_in`, in, 1: raw PS2_KBDAT pin level.
- `ps2c_oe`, out, 1: 1 pulls PS2_KBCLK low; 0 releases it (high-Z).
- `ps2d_oe`, out, 1: 1 pulls PS2_KBDAT low; 0 releases it.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done` or `error`.
- `done`, out, 1: one-cycle pulse when the device acknowledges.
- `error`, out, 1: one-cycle pulse on timeout or missing acknowledge.

## Operation
- **Input synchronisers.** `ps2c_in` and `ps2d_in` each pass through a 2-flop synchroniser. A 3rd flop on the clock path creates `fall`, which is high for one cycle when the synced clock goes 1→0.
- **Latched values.**
  - `shreg[7:0]` takes `data` on accept.
  - `par` takes `~^data` (odd parity).
  - `bitcnt[3:0]` counts device falling edges.
- **States:**
  - IDLE: both `oe` = 0. If `start` is high, latch, go to INHIBIT, counter = 0.
  - INHIBIT: `ps2c_oe` = 1. After INHIBIT_CYCLES cycles, go to START.
  - START: `ps2c_oe` = 1, `ps2d_oe` = 1. After START_HOLD cycles, go to SEND with `ps2c_oe` = 0, `ps2d_oe` = 1 (start bit), `bitcnt` = 0, watchdog = 0.
  - SEND: on each `fall`, increment `bitcnt` and drive the next bit (`ps2d_oe` = ~bit):
    - falls 1–8: `shreg` bits LSB first;
    - fall 9: parity;
    - fall 10: stop bit (`ps2d_oe` = 0).
    - After fall 10, go to ACK.
  - ACK: on the next `fall`, sample synced data.
    - 0 → WAIT_REL.
    - 1 → `error` pulse, go to IDLE.
  - WAIT_REL: when the synced clock and data are both 1, pulse `done` and go to IDLE.
- **Watchdog** (SEND, ACK, WAIT_REL): counts cycles and clears on every `fall`. On reaching TIMEOUT_CYCLES: `error` pulse, both `oe` = 0, go to IDLE.
- **Counter widths** are $clog2 of the largest of INHIBIT_CYCLES, START_HOLD and TIMEOUT_CYCLES. Counters never wrap, because every compare is an equality at terminal count.
- **Boundary conditions:**
  - `start` while busy is ignored; the latched byte is unchanged.
  - `start` in the same cycle that `done` or `error` pulses is ignored; the FSM is still leaving its terminal state.
  - A `fall` during INHIBIT or START (device glitch) is ignored.
- **Reset** (including mid-frame): both `oe` = 0, `busy`/`done`/`error` = 0, state IDLE, all counters 0. The bus is released immediately because reset is asynchronous.

## Timing
- Accept: `start` high in IDLE at edge N → `busy` = 1 and `ps2c_oe` = 1 at N+1.
- `ps2d_oe` rises at N+1+INHIBIT_CYCLES.
- `ps2c_oe` falls at N+1+INHIBIT_CYCLES+START_HOLD.
- Pin falling edge to `ps2d_oe` update: 3 cycles (2 synchroniser + 1 detect). Device half-periods are ≥30 µs, so the bit is stable well before the device's rising-edge sample.
- `done`/`error`: exactly one cycle. `busy` drops in the same cycle as the pulse.
- Frame: 11 device falling edges (10 data-phase + 1 ack), then release.

## Test plan
All scenarios use INHIBIT_CYCLES=20, START_HOLD=4, TIMEOUT_CYCLES=200, and a device model clocking at a 40-cycle period.
- **Send 0xED.** Start at cycle 0 → `ps2c_oe` high for cycles 1–24, `ps2d_oe` high from 21. Bits sampled on device rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1. Model acks 0 → one `done`, `busy` low after.
- **Send 0x01.** Parity bit must be 0. Send 0xFF → parity 1. Send 0x00 → parity 1.
- **No ack.** Model leaves data high at fall 11 → `error` pulse, no `done`, both `oe` = 0.
- **Timeout.** Model stops clocking after fall 4 → `error` exactly 200 cycles after fall 4's detect, lines released, IDLE.
- **Reset mid-frame.** `resetn` low during fall 6 → `ps2c_oe` = `ps2d_oe` = `busy` = 0 asynchronously. A new `start` after release sends a full correct frame.
- **Start while busy.** Send 0xED with `start` = 1, `data` = 0x55 at fall 3 → frame still carries 0xED, single `done`.
